iomem_pwm_leds: RTL and testbench



---
 rtl/iomem_pwm_leds_pkg.sv | 35 +++
 rtl/iomem_pwm_leds_pwm_timebase.sv | 37 +++
 rtl/iomem_pwm_leds.sv | 126 ++++++++++++
 tb/tb_iomem_pwm_leds.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pwm_leds_pkg.sv
// Shared constants, register map and helpers for the iomem LED PWM controller.
package iomem_pwm_leds_pkg;

   localparam logic [7:0]  ADDR_HI_DEFAULT = 8'h03;
   localparam int unsigned PRESC_W_MAX     = 16;
   localparam int unsigned NUM_LEDS        = 8;
   localparam int unsigned DUTY_W          = 8;
   localparam int unsigned PHASE_W         = 8;

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_DUTY_LO = 2'd1,
      REG_DUTY_HI = 2'd2,
      REG_STATUS  = 2'd3
   } reg_off_e;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_PRESC_LSB   = 16;
   localparam int unsigned STATUS_PHASE_LSB = 0;
   localparam int unsigned STATUS_EN_BIT    = 8;
   localparam int unsigned STATUS_PEND_BIT  = 16;

   // Merge write data into an old word under byte strobes.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/iomem_pwm_leds_pwm_timebase.sv
// Shared PWM timebase: prescaler and 8-bit phase counter, both held at 0 while disabled.
module iomem_pwm_leds_pwm_timebase
   import iomem_pwm_leds_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_MAX
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap
);

   logic [PRESC_W-1:0] presc_cnt;

   // A shrunken reload leaves the counter above it; it then rolls over naturally.
   assign tick = en && (presc_cnt == presc);
   assign wrap = tick && (phase == {PHASE_W{1'b1}});

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_cnt <= '0;
         phase     <= '0;
      end else if (!en) begin
         presc_cnt <= '0;
         phase     <= '0;
      end else if (tick) begin
         presc_cnt <= '0;
         phase     <= phase + PHASE_W'(1);
      end else begin
         presc_cnt <= presc_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/iomem_pwm_leds.sv
// iomem slave driving 8 LEDs with double-buffered 8-bit PWM duties.
module iomem_pwm_leds
   import iomem_pwm_leds_pkg::*;
#(
   parameter logic [7:0]  ADDR_HI = ADDR_HI_DEFAULT,
   parameter int unsigned PRESC_W = PRESC_W_MAX
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int unsigned DUTY_BITS = NUM_LEDS * DUTY_W;

   logic                 en_q;
   logic [PRESC_W-1:0]   presc_q;
   logic [DUTY_BITS-1:0] duty_reg;
   logic [DUTY_BITS-1:0] duty_act;
   logic                 pend_q;

   logic                 tick;
   logic                 wrap;
   logic [PHASE_W-1:0]   phase;

   logic                 sel_c;
   logic                 wr_c;
   logic                 load_c;
   reg_off_e             off_c;
   logic [31:0]          ctrl_c;
   logic [31:0]          status_c;
   logic [31:0]          rdata_c;
   logic [31:0]          ctrl_new_c;
   logic [NUM_LEDS-1:0]  leds_nxt_c;
   logic                 unused_c;

   iomem_pwm_leds_pwm_timebase #(
      .PRESC_W (PRESC_W)
   ) u_timebase (
      .clk    (clk),
      .resetn (resetn),
      .en     (en_q),
      .presc  (presc_q),
      .tick   (tick),
      .phase  (phase),
      .wrap   (wrap)
   );

   assign sel_c  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
   assign wr_c   = sel_c && (iomem_wstrb != 4'h0);
   assign off_c  = reg_off_e'(iomem_addr[3:2]);
   assign load_c = !en_q || wrap;

   // Register views and read mux; reads always return the pre-write value.
   always_comb begin
      ctrl_c   = '0;
      status_c = '0;
      ctrl_c[CTRL_EN_BIT]                      = en_q;
      ctrl_c[CTRL_PRESC_LSB +: PRESC_W]        = presc_q;
      status_c[STATUS_PHASE_LSB +: PHASE_W]    = phase;
      status_c[STATUS_EN_BIT]                  = en_q;
      status_c[STATUS_PEND_BIT]                = pend_q;
      case (off_c)
         REG_CTRL:    rdata_c = ctrl_c;
         REG_DUTY_LO: rdata_c = duty_reg[31:0];
         REG_DUTY_HI: rdata_c = duty_reg[63:32];
         default:     rdata_c = status_c;
      endcase
      ctrl_new_c = apply_wstrb(ctrl_c, iomem_wdata, iomem_wstrb);
   end

   always_comb begin
      leds_nxt_c = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         leds_nxt_c[i] = en_q && (phase < duty_act[DUTY_W*i +: DUTY_W]);
      end
   end

   // Address bits outside the page/offset fields alias by design.
   assign unused_c = ^{iomem_addr[23:4], iomem_addr[1:0], tick, ctrl_new_c};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         en_q        <= 1'b0;
         presc_q     <= '0;
         duty_reg    <= '0;
         duty_act    <= '0;
         pend_q      <= 1'b0;
         leds        <= '0;
      end else begin
         iomem_ready <= sel_c;
         iomem_rdata <= sel_c ? rdata_c : '0;
         leds        <= leds_nxt_c;
         if (load_c) begin
            duty_act <= duty_reg;
            pend_q   <= 1'b0;
         end
         // A duty write coinciding with a load keeps PEND set for the next boundary.
         if (wr_c) begin
            case (off_c)
               REG_CTRL: begin
                  en_q    <= ctrl_new_c[CTRL_EN_BIT];
                  presc_q <= ctrl_new_c[CTRL_PRESC_LSB +: PRESC_W];
               end
               REG_DUTY_LO: begin
                  duty_reg[31:0] <= apply_wstrb(duty_reg[31:0], iomem_wdata, iomem_wstrb);
                  pend_q         <= 1'b1;
               end
               REG_DUTY_HI: begin
                  duty_reg[63:32] <= apply_wstrb(duty_reg[63:32], iomem_wdata, iomem_wstrb);
                  pend_q          <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iomem_pwm_leds.sv
// Directed self-checking bench for iomem_pwm_leds.
module tb_iomem_pwm_leds;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [7:0]  leds;

   int n_checks = 0;
   int n_fail   = 0;
   int hi_cnt [8];

   always #5 clk = ~clk;

   iomem_pwm_leds dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .leds        (leds)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One bus transfer; ok reports whether a ready pulse arrived within 4 cycles.
   task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, output logic [31:0] rd, output bit ok);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = wstrb;
      iomem_wdata = wdata;
      ok = 1'b0;
      rd = '0;
      for (int i = 0; i < 4 && !ok; i++) begin
         @(posedge clk); #1;
         if (iomem_ready) begin
            ok = 1'b1;
            rd = iomem_rdata;
         end
      end
      @(negedge clk);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata);
      logic [31:0] rd;
      bit ok;
      bus(addr, wstrb, wdata, rd, ok);
      check({tag, "_ack"}, 32'(ok), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      bit ok;
      bus(addr, 4'h0, 32'h0, rd, ok);
      check({tag, "_ack"}, 32'(ok), 32'd1);
      check(tag, rd, exp);
   endtask

   task automatic count_leds(input int n);
      for (int b = 0; b < 8; b++) hi_cnt[b] = 0;
      repeat (n) begin
         @(posedge clk); #1;
         for (int b = 0; b < 8; b++) if (leds[b]) hi_cnt[b]++;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, s1, s2;
      bit          ok;
      int          polls, waited, run, sum;

      resetn      = 1'b0;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_addr  = '0;
      iomem_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_leds",  32'(leds), 32'h0);
      check("rst_ready", 32'(iomem_ready), 32'h0);
      check("rst_rdata", iomem_rdata, 32'h0);
      resetn = 1'b1;

      // Reset-state reads and single-cycle ready pulse
      rd_chk("ctrl_rst", 32'h0300_0000, 32'h0);
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(iomem_ready), 32'h0);
      rd_chk("status_rst", 32'h0300_000C, 32'h0);

      // Back-to-back: valid held high gives ready on alternate cycles
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0004;
      iomem_wstrb = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("b2b_ready", 32'(iomem_ready), 32'((i % 2) == 0));
      end
      @(negedge clk);
      iomem_valid = 1'b0;

      // Aliased CTRL byte-0 write enables with PRESC=0
      wr("ctrl_alias_wr", 32'h0300_0010, 4'h1, 32'h0000_007F);
      rd_chk("ctrl_alias_rd", 32'h0300_0000, 32'h0000_0001);

      wr("duty_lo_wr", 32'h0300_0004, 4'hF, 32'h00FF_8040);
      rd_chk("duty_lo_rd", 32'h0300_0004, 32'h00FF_8040);
      polls = 0;
      do begin
         bus(32'h0300_000C, 4'h0, 32'h0, rd, ok);
         polls++;
      end while (rd[16] && polls < 200);
      check("pend_clears", 32'(rd[16]), 32'h0);
      count_leds(256);
      check("duty0_64",  32'(hi_cnt[0]), 32'd64);
      check("duty1_128", 32'(hi_cnt[1]), 32'd128);
      check("duty2_255", 32'(hi_cnt[2]), 32'd255);
      check("duty3_0",   32'(hi_cnt[3]), 32'd0);
      check("duty7_0",   32'(hi_cnt[7]), 32'd0);

      // PRESC=3: period 1024 cycles, phase advances every 4 cycles
      wr("presc_wr", 32'h0300_0000, 4'h5, 32'h0003_0001);
      rd_chk("presc_rd", 32'h0300_0000, 32'h0003_0001);
      repeat (8) @(posedge clk);
      count_leds(1024);
      check("p3_duty0", 32'(hi_cnt[0]), 32'd256);
      check("p3_duty1", 32'(hi_cnt[1]), 32'd512);
      check("p3_duty2", 32'(hi_cnt[2]), 32'd1020);
      check("p3_duty3", 32'(hi_cnt[3]), 32'd0);
      bus(32'h0300_000C, 4'h0, 32'h0, s1, ok);
      repeat (63) @(posedge clk);
      bus(32'h0300_000C, 4'h0, 32'h0, s2, ok);
      check("status_en",   32'(s1[8]), 32'h1);
      check("phase_step",  32'(s2[7:0]), 32'(8'(s1[7:0] + 8'd16)));

      // Duty write mid-period stays pending until the phase wraps
      polls = 0;
      do begin
         bus(32'h0300_000C, 4'h0, 32'h0, rd, ok);
         polls++;
      end while (!(rd[7:0] >= 8'd100 && rd[7:0] <= 8'd130) && polls < 600);
      check("phase_found", 32'(rd[7:0] >= 8'd100 && rd[7:0] <= 8'd130), 32'h1);
      wr("duty_hi_wr", 32'h0300_0008, 4'h2, 32'h0000_1000);
      bus(32'h0300_000C, 4'h0, 32'h0, rd, ok);
      check("pend_set", 32'(rd[16]), 32'h1);
      check("led5_before", 32'(leds[5]), 32'h0);
      waited = 0;
      while (!leds[5] && waited < 2000) begin
         @(posedge clk); #1;
         waited++;
      end
      check("led5_rises", 32'(leds[5]), 32'h1);
      check("led5_not_early", 32'(waited > 400), 32'h1);
      run = 1;
      while (run < 200) begin
         @(posedge clk); #1;
         if (!leds[5]) break;
         run++;
      end
      check("led5_high_run", 32'(run), 32'd64);
      rd_chk("duty_hi_rd", 32'h0300_0008, 32'h0000_1000);
      bus(32'h0300_000C, 4'h0, 32'h0, rd, ok);
      check("pend_after_wrap", 32'(rd[16]), 32'h0);

      // Foreign page gets no response; STATUS writes are acked and ignored
      bus(32'h0200_0000, 4'hF, 32'hFFFF_FFFF, rd, ok);
      check("foreign_no_ack", 32'(ok), 32'h0);
      rd_chk("ctrl_after_foreign", 32'h0300_0000, 32'h0003_0001);
      wr("status_wr", 32'h0300_000C, 4'hF, 32'hFFFF_FFFF);
      bus(32'h0300_000C, 4'h0, 32'h0, rd, ok);
      check("status_ro", rd & 32'hFFFF_FF00, 32'h0000_0100);

      // Async reset mid-transfer and mid-period
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0000;
      iomem_wstrb = 4'h0;
      @(posedge clk); #1;
      check("ready_before_rst", 32'(iomem_ready), 32'h1);
      resetn = 1'b0;
      #1;
      check("rst_async_ready", 32'(iomem_ready), 32'h0);
      check("rst_async_leds",  32'(leds), 32'h0);
      check("rst_async_rdata", iomem_rdata, 32'h0);
      iomem_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      check("no_ack_after_rst", 32'(iomem_ready), 32'h0);
      rd_chk("ctrl_after_rst",    32'h0300_0000, 32'h0);
      rd_chk("duty_lo_after_rst", 32'h0300_0004, 32'h0);
      rd_chk("duty_hi_after_rst", 32'h0300_0008, 32'h0);
      rd_chk("status_after_rst",  32'h0300_000C, 32'h0);
      count_leds(300);
      sum = 0;
      for (int b = 0; b < 8; b++) sum += hi_cnt[b];
      check("leds_off_after_rst", 32'(sum), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
